dct_scheduler: RTL and testbench
================================

DCT_SCHEDULER -- requirements
Module: dct_scheduler

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 40: log-mel inputs per frame (DCT length N).
REQ-002 SHALL have parameter NUM_CEPS, default 12: cepstral coefficients per frame (K).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: log-mel sample valid.
REQ-006 SHALL have port in_ready, output, 1 bit: scheduler accepts a sample.
REQ-007 SHALL have port in_data, input, 16 bits: signed log-mel energy.
REQ-008 SHALL have port out_valid, output, 1 bit: coefficient valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the coefficient.
REQ-010 SHALL have port out_data, output, 16 bits: signed cepstral coefficient.
REQ-011 SHALL have port out_idx, output, 4 bits: coefficient index k.
REQ-012 SHALL have port out_last, output, 1 bit: high with k = NUM_CEPS-1.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL be a single-multiplier scheduler: c[k] = sum over n of x[n]*cos_table[n][k], for k = 0..K-1 and n = 0..N-1; cos_table is signed Q15.
REQ-015 SHALL use states IDLE, LOAD, MAC, DRAIN, OUT.
REQ-016 SHALL move IDLE->LOAD unconditionally one cycle after reset release.
REQ-017 SHALL drive in_ready high only in LOAD; a handshake (in_valid & in_ready) writes in_data to buffer[n_cnt] and increments n_cnt; in_valid outside LOAD is ignored.
REQ-018 SHALL enter MAC on the cycle after the N-th accepted sample, with k = 0 and the accumulator cleared.
REQ-019 SHALL, in MAC, issue addresses n = 0..N-1 on consecutive cycles, one per cycle, without stalling.
REQ-020 SHALL use a 3-stage pipeline (buffer/ROM read register, product register, accumulate); DRAIN lasts 3 cycles, so out_valid rises exactly N+3 = 43 cycles after MAC entry.
REQ-021 SHALL form products at 32-bit signed precision, accumulate at 38 bits, then compute out_data = saturate16(acc >>> 15) using arithmetic shift (floor), clamped to [-32768, 32767].
REQ-022 SHALL, in OUT, hold out_valid, out_data, out_idx and out_last stable until out_ready; on the handshake it SHALL go to MAC with k+1 and the accumulator cleared, or to LOAD with n_cnt = 0 if k = K-1.
REQ-023 SHALL accept no new input while a frame is being computed; the buffer is overwritten only in the next LOAD.
REQ-024 SHALL complete an out handshake in the same cycle that out_valid rises when out_ready is already high.

Reset
REQ-025 SHALL, on rst_n low, immediately set the state to IDLE and clear n_cnt, k, the accumulator and the pipeline valid bits; outputs SHALL be in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
REQ-026 SHALL discard a partial frame or partial coefficient when reset is asserted mid-operation; buffer contents need no reset.

Structure
REQ-027 SHALL place NUM_FILTERS, NUM_CEPS, data/product/accumulator widths and the state enum typedef in shared package mfcc_pkg.
REQ-028 SHALL instantiate one sub-module, dct_cos_rom: 40x12 Q15 cosine table with a registered read (1-cycle latency) addressed by (n, k).

Verification
REQ-029 SHALL pass: impulse x[0]=32767, others 0 -> c0=32766, c1=32741.
REQ-030 SHALL pass: x[39]=-32768, others 0 -> c0=-32767, c1=32742.
REQ-031 SHALL pass: all x=100 -> c0=3999, every odd k=0, every even k≥2 with |c|≤2; all x=1000 -> c0 saturates to 32767.
REQ-032 SHALL pass: out_ready held low 10 cycles at k=3 -> out_data/out_idx stable, in_ready=0, k=4 follows the handshake; out_last only on k=11.
REQ-033 SHALL pass: rst_n pulsed low during MAC of k=5 -> all outputs 0 at once; after release, a fresh frame yields correct c0..c11 with no stale data.
REQ-034 SHALL pass: in_valid toggled randomly during LOAD, out_ready always high -> first out_valid exactly 43 cycles after MAC entry, and 12 coefficients per frame.

Source files
------------

// File: rtl/mfcc_pkg.sv
// Shared constants, types and helpers for the MFCC DCT stage.
package mfcc_pkg;

    localparam int NUM_FILTERS  = 40;
    localparam int NUM_CEPS     = 12;
    localparam int DATA_W       = 16;
    localparam int COEF_W       = 16;
    localparam int PROD_W       = 32;
    localparam int ACC_W        = 38;
    localparam int FRAC_W       = 15;
    localparam int DRAIN_CYCLES = 3;

    // pi in Q30, used only while elaborating the cosine table
    localparam longint PI_Q30 = 64'sd3373259426;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN,
        OUT
    } state_t;

    // round(32767 * cos(pi * m / 80)), rounded half away from zero.
    // Angle is folded into the first quadrant and a Taylor series is
    // evaluated in Q30 so the table is built at elaboration time.
    function automatic logic signed [COEF_W-1:0] cos_q15(input int m);
        int     a;
        logic   neg;
        longint th;
        longint th2;
        longint term;
        longint sum;
        longint r;
        a   = m % 160;
        if (a > 80) a = 160 - a;
        neg = 1'b0;
        if (a > 40) begin
            a   = 80 - a;
            neg = 1'b1;
        end
        th   = (PI_Q30 * longint'(a)) / 64'sd80;
        th2  = (th * th) >>> 30;
        term = 64'sd1 <<< 30;
        sum  = term;
        for (int unsigned i = 1; i <= 12; i++) begin
            term = -((term * th2) >>> 30) / longint'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        r = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
        if (neg) r = -r;
        return r[COEF_W-1:0];
    endfunction

    // Q15 rescale with floor rounding, clamped to the 16-bit signed range
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC_W;
        if (sh > ACC_W'(32'sd32767))
            return 16'sh7fff;
        else if (sh < ACC_W'(-32'sd32768))
            return 16'sh8000;
        else
            return sh[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// DCT-II cosine table in Q15, one registered read per cycle addressed by (n, k).
module dct_cos_rom #(
    parameter int NUM_FILTERS = mfcc_pkg::NUM_FILTERS,
    parameter int NUM_CEPS    = mfcc_pkg::NUM_CEPS,
    parameter int N_W         = $clog2(NUM_FILTERS)
) (
    input  logic           clk,
    input  logic [N_W-1:0] n,
    input  logic [3:0]     k,
    output logic [15:0]    coef
);
    import mfcc_pkg::*;

    logic [COEF_W-1:0] table_q15 [NUM_FILTERS][NUM_CEPS];

    // Entry (n, k) = cos(pi * k * (2n+1) / 80), folded onto a 160-step circle
    for (genvar gn = 0; gn < NUM_FILTERS; gn++) begin : g_n
        for (genvar gk = 0; gk < NUM_CEPS; gk++) begin : g_k
            localparam logic [COEF_W-1:0] COS_VAL = cos_q15(gk * (2 * gn + 1));
            assign table_q15[gn][gk] = COS_VAL;
        end
    end

    // Registered read, one cycle latency
    always_ff @(posedge clk) begin
        coef <= table_q15[n][k];
    end

endmodule

// File: rtl/dct_scheduler.sv
// Single-multiplier DCT scheduler: buffers one frame of log-mel energies, then
// computes each cepstral coefficient with a 3-stage MAC pipeline.
module dct_scheduler #(
    parameter int NUM_FILTERS = mfcc_pkg::NUM_FILTERS,
    parameter int NUM_CEPS    = mfcc_pkg::NUM_CEPS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        busy
);
    import mfcc_pkg::*;

    localparam int N_W = $clog2(NUM_FILTERS);

    state_t                    state;
    state_t                    next_state;
    logic [N_W-1:0]            n_cnt;
    logic [3:0]                k;
    logic [1:0]                drain_cnt;
    logic signed [DATA_W-1:0]  buffer [NUM_FILTERS];
    logic signed [DATA_W-1:0]  x_r;
    logic [COEF_W-1:0]         coef_r;
    logic                      v1;
    logic                      v2;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc;
    logic                      issue;
    logic                      load_fire;
    logic                      out_fire;
    logic                      last_n;
    logic                      last_k;
    logic                      last_drain;
    logic                      acc_clr;

    assign load_fire  = in_ready & in_valid;
    assign out_fire   = out_valid & out_ready;
    assign last_n     = (n_cnt == N_W'(NUM_FILTERS - 1));
    assign last_k     = (k == 4'(NUM_CEPS - 1));
    assign last_drain = (drain_cnt == 2'(DRAIN_CYCLES - 1));
    assign acc_clr    = (state != MAC) && (next_state == MAC);

    assign out_data = out_valid ? sat16(acc) : '0;
    assign out_idx  = k;
    assign out_last = out_valid & last_k;

    dct_cos_rom #(
        .NUM_FILTERS(NUM_FILTERS),
        .NUM_CEPS   (NUM_CEPS)
    ) u_cos_rom (
        .clk (clk),
        .n   (n_cnt),
        .k   (k),
        .coef(coef_r)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = LOAD;
            LOAD:    if (load_fire && last_n) next_state = MAC;
            MAC:     if (last_n) next_state = DRAIN;
            DRAIN:   if (last_drain) next_state = OUT;
            OUT:     if (out_ready) next_state = last_k ? LOAD : MAC;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs and MAC issue strobe
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        issue     = 1'b0;
        unique case (state)
            IDLE:    busy      = 1'b0;
            LOAD:    in_ready  = 1'b1;
            MAC:     issue     = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Frame buffer; written only while loading
    always_ff @(posedge clk) begin
        if (load_fire) buffer[n_cnt] <= in_data;
    end

    // Counters and MAC pipeline: read regs -> product reg -> accumulator.
    // n_cnt wraps to 0 after the last sample/address, so it is ready for the
    // next phase without an explicit clear on the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cnt     <= '0;
            k         <= '0;
            drain_cnt <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            x_r       <= '0;
            prod      <= '0;
            acc       <= '0;
        end else begin
            if (load_fire || issue) n_cnt <= last_n ? '0 : n_cnt + N_W'(1);
            if (state == DRAIN) drain_cnt <= last_drain ? '0 : drain_cnt + 2'd1;
            if (out_fire) k <= last_k ? '0 : k + 4'd1;
            v1   <= issue;
            x_r  <= buffer[n_cnt];
            v2   <= v1;
            prod <= PROD_W'(x_r) * PROD_W'(signed'(coef_r));
            if (acc_clr)  acc <= '0;
            else if (v2)  acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: tb/tb_dct_scheduler.sv
// Self-checking bench for dct_scheduler: frame-level reference model plus a
// table of hand-computed coefficient expectations.
module tb_dct_scheduler;

    localparam int N = 40;
    localparam int K = 12;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int x   [N];
    int got [K];
    int res [7][K];

    typedef struct {
        int pat;
        int k;
        int exp;
        int tol;
    } vec_t;
    vec_t vecs[$];

    dct_scheduler #(.NUM_FILTERS(N), .NUM_CEPS(K)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, exp, tol);
        end
    endtask

    function automatic int cos_ref(input int n, input int k);
        real v;
        v = 32767.0 * $cos(PI * k * (2 * n + 1) / (2.0 * N));
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(-v + 0.5);
    endfunction

    function automatic int model(input int k);
        longint acc;
        longint sh;
        acc = 0;
        for (int n = 0; n < N; n++) acc += longint'(x[n]) * longint'(cos_ref(n, k));
        sh = acc >>> 15;
        if (sh > 32767)  sh = 32767;
        if (sh < -32768) sh = -32768;
        return int'(sh);
    endfunction

    function automatic int pattern(input int p, input int n);
        case (p)
            0:       return (n == 0) ? 32767 : 0;
            1:       return (n == N - 1) ? -32768 : 0;
            2:       return 100;
            3:       return 1000;
            4:       return ((n * 7919 + 1237) % 65536) - 32768;
            5:       return -1000;
            default: return ((n * 4099 + 311) % 20001) - 10000;
        endcase
    endfunction

    function automatic int outs_vec();
        return int'({in_ready, out_valid, out_data, out_idx, out_last, busy});
    endfunction

    // Feeds one frame; returns at the negedge of the first MAC cycle
    task automatic load_frame(input int p, input bit rnd);
        int i;
        int guard;
        i = 0;
        guard = 0;
        for (int n = 0; n < N; n++) x[n] = pattern(p, n);
        while (i < N && guard < 2000) begin
            @(negedge clk);
            guard++;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = 16'(x[i]);
            if (in_valid && in_ready) i++;
        end
        if (i < N) check("load_timeout", i, N);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collects coefficients; optional stall on one index or reset during MAC of abort_k
    task automatic collect(input bit rnd, input int stall_k, input int abort_k);
        int c;
        int cur;
        int hold;
        int last_c;
        int bad_rdy;
        bit seen;
        bit drop;
        bit hs;
        logic [15:0] hd;
        logic [3:0]  hi;
        c = 0; cur = 0; hold = 0; last_c = 0; bad_rdy = 0;
        seen = 0; drop = 0; hd = '0; hi = '0;
        out_ready = 1'b1;
        while (cur < K) begin
            if (c > 3000) begin
                check("collect_timeout", cur, K);
                break;
            end
            if (in_ready) bad_rdy++;
            if (cur == abort_k && c == last_c + 10) begin
                rst_n = 1'b0;
                #1;
                check("abort_reset_outputs", outs_vec(), 0);
                in_valid = 1'b0;
                return;
            end
            if (out_valid) begin
                hs = 0;
                if (!seen) begin
                    seen = 1;
                    hd = out_data;
                    hi = out_idx;
                    check($sformatf("latency_k%0d", cur), c, (cur == 0) ? N + 3 : last_c + N + 4);
                end else begin
                    check("stall_hold", int'({out_data, out_idx}), int'({hd, hi}));
                end
                if (out_ready) hs = 1;
                else begin
                    hold++;
                    if (hold == 10) begin
                        out_ready = 1'b1;
                        hs = 1;
                    end
                end
                if (hs) begin
                    got[cur] = int'($signed(out_data));
                    check("out_idx", int'(out_idx), cur);
                    check("out_last", int'(out_last), (cur == K - 1) ? 1 : 0);
                    check($sformatf("coef_k%0d", cur), got[cur], model(cur));
                    cur++;
                    seen = 0;
                    last_c = c;
                    if (cur == stall_k) drop = 1;
                end
            end else if (drop) begin
                out_ready = 1'b0;
                drop = 0;
                hold = 0;
            end
            if (rnd) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 16'($urandom);
            end
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        check("in_ready_low_during_compute", bad_rdy, 0);
        check("coef_count", cur, K);
    endtask

    task automatic run_frame(input int p, input bit rnd, input int stall_k);
        load_frame(p, rnd);
        collect(rnd, stall_k, -1);
        for (int k = 0; k < K; k++) res[p][k] = got[k];
    endtask

    initial begin
        vecs.push_back('{0, 0, 32766, 0});
        vecs.push_back('{0, 1, 32741, 0});
        vecs.push_back('{1, 0, -32767, 0});
        vecs.push_back('{1, 1, 32742, 0});
        vecs.push_back('{2, 0, 3999, 0});
        for (int k = 1; k < K; k += 2) vecs.push_back('{2, k, 0, 0});
        for (int k = 2; k < K; k += 2) vecs.push_back('{2, k, 0, 2});
        vecs.push_back('{3, 0, 32767, 0});
        vecs.push_back('{3, 1, 0, 0});
        vecs.push_back('{5, 0, -32768, 0});

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        check("idle_busy", int'(busy), 0);
        @(negedge clk);
        check("load_in_ready", int'(in_ready), 1);
        check("load_busy", int'(busy), 1);

        run_frame(0, 1'b0, -1);
        run_frame(1, 1'b0, -1);
        run_frame(2, 1'b0, -1);
        run_frame(3, 1'b0, -1);
        run_frame(5, 1'b0, -1);
        run_frame(4, 1'b1, -1);
        run_frame(6, 1'b0, 3);

        // Reset in the middle of coefficient 5, then a clean frame
        load_frame(4, 1'b0);
        collect(1'b0, -1, 5);
        repeat (2) @(negedge clk);
        check("held_reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        run_frame(1, 1'b0, -1);

        foreach (vecs[i]) begin
            check_tol($sformatf("vec%0d_p%0d_k%0d", i, vecs[i].pat, vecs[i].k),
                      res[vecs[i].pat][vecs[i].k], vecs[i].exp, vecs[i].tol);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
